multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle sequencing controller for the processor datapath. It replaces single-cycle control where the instruction and data memory is shared and may insert wait states. It steps each instruction through FETCH / DECODE / EXEC / MEM / WB. Per cycle it drives the datapath mux selects, write enables and ALU operation, and it handshakes with the shared memory port. It also flags illegal opcodes and counts retired instructions.

## Interface
- `RETIRE_W`, 32, width of the retired-instruction counter
- `clk`  in  1  single system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `alu_zero`  in  1  ALU zero flag, same cycle
- `mem_ready`  in  1  memory completes current request this cycle
- `mem_req`  out  1  memory request, held until `mem_ready`
- `mem_we`  out  1  write request (SW only)
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load instruction register
- `pc_write`  out  1  load PC
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target, 11 = rs
- `alu_src_a`  out  1  ALU A operand: 0 = PC, 1 = rs
- `alu_src_b`  out  2  ALU B operand: 00 = rt, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- `alu_op`  out  4  0000 add, 0001 sub, 0010 R-type funct, 0011 and, 0100 or, 0101 xor, 0110 lui, 0111 slt, 1000 sltu
- `zero_ext`  out  1  1 = zero-extend immediate (ANDI/ORI/XORI), 0 = sign-extend
- `reg_write`  out  1  register file write enable
- `reg_dst`  out  2  destination register: 00 = rt, 01 = rd, 10 = r31
- `mem_to_reg`  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC
- `trap`  out  1  sticky illegal-opcode flag
- `retired`  out  RETIRE_W  count of completed instructions

## Operation
- Opcodes: R 000000 (JR = funct 001000), ADDI 000001, ANDI 000010, ORI 000011, XORI 000100, BEQ 000101, BNE 000110, SLTI 000111, SLTIU 001000, LUI 001001, LW 001010, SW 001011, J 001100, JAL 001101.
- FETCH:
  - `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=add.
  - Stay in FETCH while `mem_ready`=0.
  - When `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, go to DECODE.
- DECODE:
  - `alu_src_a`=0, `alu_src_b`=11, add (branch target written to ALUOut).
  - J: `pc_write`, `pc_src`=10, go to FETCH.
  - JAL: as J, plus `reg_write`, `reg_dst`=10, `mem_to_reg`=10.
  - JR: `pc_write`, `pc_src`=11, go to FETCH.
  - Undefined opcode: go to TRAP.
  - All others: go to EXEC.
- EXEC:
  - `alu_src_a`=1.
  - R-type: `alu_src_b`=00, `alu_op`=0010, then WB.
  - I-type ALU ops: `alu_src_b`=10, `alu_op` per opcode, `zero_ext`=1 for ANDI/ORI/XORI, then WB.
  - BEQ/BNE: `alu_src_b`=00, sub, `pc_src`=01.
    - BEQ: `pc_write`=`alu_zero`; BNE: `pc_write`=!`alu_zero`.
    - Go to FETCH.
  - LW/SW: `alu_src_b`=10, add, then MEM.
- MEM:
  - `mem_req`=1, `iord`=1, `mem_we`=1 for SW.
  - Hold while `mem_ready`=0.
  - On `mem_ready`: SW goes to FETCH, LW goes to WB.
- WB:
  - `reg_write`=1.
  - `reg_dst`=01 for R-type, 00 otherwise.
  - `mem_to_reg`=01 for LW, 00 otherwise.
  - Go to FETCH.
- TRAP: all enables 0, `trap`=1; the only exit is reset.
- `retired` increments by 1 in each instruction's final cycle: the cycle whose next state is FETCH. It wraps modulo 2^RETIRE_W.

## Timing
- Reset (asynchronous, active-low, `rst_n`):
  - Immediately on assertion: state = FETCH, `trap`=0, `retired`=0.
  - While `rst_n`=0, every control output is forced to 0.
  - The first `mem_req` appears in the first cycle after deassertion.
  - Reset asserted mid-instruction aborts it with no further writes.
- Output timing:
  - Outputs are combinational decodes of the state register and `opcode`/`funct`.
  - `pc_write`, `ir_write` and the state advance also depend on `mem_ready` and `alu_zero` in the same cycle.
- Memory handshake:
  - While `mem_req`=1 and `mem_ready`=0, `iord`/`mem_we` stay stable.
  - `mem_ready` is ignored whenever `mem_req`=0.
  - Exactly one transfer completes per high `mem_ready` cycle.
- Latency with zero-wait memory (each wait cycle adds 1):
  - J/JAL/JR: 2 cycles
  - BEQ/BNE: 3 cycles
  - R-type, I-type, SW: 4 cycles
  - LW: 5 cycles

## Structure
- Shared package holds:
  - opcode and funct localparams
  - ALUOp codes
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, TRAP; 3-bit)
  - `pc_src`, `alu_src_b`, `reg_dst` and `mem_to_reg` select codes
- Sub-module `instr_class_decode`: combinational map from `opcode`/`funct` to an instruction class and its `alu_op`/`zero_ext`; the FSM consumes the class.

## Test plan
- ADDI with `mem_ready` tied 1 → 4 cycles FETCH→DECODE→EXEC→WB; in EXEC `alu_op`=0000, `alu_src_b`=10; in WB `reg_write`=1, `reg_dst`=00; `retired` 0→1.
- LW with `mem_ready` low 2 cycles in FETCH and 3 in MEM → 10 cycles; `mem_req` and `iord` stable throughout each wait; WB has `mem_to_reg`=01.
- BEQ with `alu_zero`=1, then BNE with `alu_zero`=1 → BEQ asserts `pc_write` with `pc_src`=01 in EXEC; BNE keeps `pc_write`=0; each takes 3 cycles.
- JAL → DECODE asserts `pc_write`, `pc_src`=10, `reg_write`, `reg_dst`=10, `mem_to_reg`=10; FETCH follows; total 2 cycles.
- Opcode 111111 → TRAP; `trap`=1 and all enables 0 for 20 cycles; `rst_n` pulse clears `trap` and resumes FETCH.
- `rst_n` asserted during MEM of SW with `mem_ready`=0 → outputs drop to 0 in the same cycle; after release, FETCH with `mem_req`=1 and `retired` unchanged at 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU ops,
// FSM states, datapath select codes and the decoded instruction class.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b000001;
    localparam logic [5:0] OP_ANDI  = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b000011;
    localparam logic [5:0] OP_XORI  = 6'b000100;
    localparam logic [5:0] OP_BEQ   = 6'b000101;
    localparam logic [5:0] OP_BNE   = 6'b000110;
    localparam logic [5:0] OP_SLTI  = 6'b000111;
    localparam logic [5:0] OP_SLTIU = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b001010;
    localparam logic [5:0] OP_SW    = 6'b001011;
    localparam logic [5:0] OP_J     = 6'b001100;
    localparam logic [5:0] OP_JAL   = 6'b001101;

    localparam logic [5:0] FN_JR = 6'b001000;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_RTYPE = 4'b0010;
    localparam logic [3:0] ALU_AND   = 4'b0011;
    localparam logic [3:0] ALU_OR    = 4'b0100;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_LUI   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_SLTU  = 4'b1000;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    typedef enum logic [3:0] {
        CLS_R,
        CLS_JR,
        CLS_IALU,
        CLS_BEQ,
        CLS_BNE,
        CLS_LW,
        CLS_SW,
        CLS_J,
        CLS_JAL,
        CLS_ILL
    } instr_class_e;

endpackage

// File: rtl/multicycle_ctrl_class_decode.sv
// Maps opcode/funct to an instruction class plus the ALU operation
// and immediate extension mode used in EXEC.
module instr_class_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_e cls,
    output logic [3:0]   alu_op,
    output logic         zero_ext
);

    always_comb begin
        cls      = CLS_ILL;
        alu_op   = ALU_ADD;
        zero_ext = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                cls    = (funct == FN_JR) ? CLS_JR : CLS_R;
                alu_op = ALU_RTYPE;
            end
            OP_ADDI: cls = CLS_IALU;
            OP_ANDI: begin
                cls      = CLS_IALU;
                alu_op   = ALU_AND;
                zero_ext = 1'b1;
            end
            OP_ORI: begin
                cls      = CLS_IALU;
                alu_op   = ALU_OR;
                zero_ext = 1'b1;
            end
            OP_XORI: begin
                cls      = CLS_IALU;
                alu_op   = ALU_XOR;
                zero_ext = 1'b1;
            end
            OP_SLTI: begin
                cls    = CLS_IALU;
                alu_op = ALU_SLT;
            end
            OP_SLTIU: begin
                cls    = CLS_IALU;
                alu_op = ALU_SLTU;
            end
            OP_LUI: begin
                cls    = CLS_IALU;
                alu_op = ALU_LUI;
            end
            OP_BEQ: begin
                cls    = CLS_BEQ;
                alu_op = ALU_SUB;
            end
            OP_BNE: begin
                cls    = CLS_BNE;
                alu_op = ALU_SUB;
            end
            OP_LW:  cls = CLS_LW;
            OP_SW:  cls = CLS_SW;
            OP_J:   cls = CLS_J;
            OP_JAL: cls = CLS_JAL;
            default: cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath
// selects and a shared memory port; traps on illegal opcodes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                alu_zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [3:0]          alu_op,
    output logic                zero_ext,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                trap,
    output logic [RETIRE_W-1:0] retired
);

    logic [2:0]          state_q, state_d;
    logic [RETIRE_W-1:0] retired_q;
    instr_class_e        cls;
    logic [3:0]          dec_alu_op;
    logic                dec_zero_ext;

    instr_class_decode u_dec (
        .opcode   (opcode),
        .funct    (funct),
        .cls      (cls),
        .alu_op   (dec_alu_op),
        .zero_ext (dec_zero_ext)
    );

    // Outputs are forced low while reset is held, not just after the edge.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        zero_ext   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        trap       = 1'b0;
        state_d    = state_q;
        if (rst_n) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_b = SRCB_IMM_SH2;
                    unique case (cls)
                        CLS_J: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            state_d  = S_FETCH;
                        end
                        CLS_JAL: begin
                            pc_write   = 1'b1;
                            pc_src     = PC_JUMP;
                            reg_write  = 1'b1;
                            reg_dst    = DST_RA;
                            mem_to_reg = WB_PC;
                            state_d    = S_FETCH;
                        end
                        CLS_JR: begin
                            pc_write = 1'b1;
                            pc_src   = PC_RS;
                            state_d  = S_FETCH;
                        end
                        CLS_ILL: state_d = S_TRAP;
                        default: state_d = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = dec_alu_op;
                    zero_ext  = dec_zero_ext;
                    unique case (cls)
                        CLS_R: begin
                            alu_src_b = SRCB_RT;
                            state_d   = S_WB;
                        end
                        CLS_IALU: begin
                            alu_src_b = SRCB_IMM;
                            state_d   = S_WB;
                        end
                        CLS_BEQ, CLS_BNE: begin
                            alu_src_b = SRCB_RT;
                            pc_src    = PC_ALUOUT;
                            pc_write  = (cls == CLS_BEQ) ? alu_zero : !alu_zero;
                            state_d   = S_FETCH;
                        end
                        CLS_LW, CLS_SW: begin
                            alu_src_b = SRCB_IMM;
                            state_d   = S_MEM;
                        end
                        default: state_d = S_TRAP;
                    endcase
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = (cls == CLS_SW);
                    if (mem_ready) begin
                        state_d = (cls == CLS_SW) ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls == CLS_R) ? DST_RD : DST_RT;
                    mem_to_reg = (cls == CLS_LW) ? WB_MDR : WB_ALUOUT;
                    state_d    = S_FETCH;
                end
                S_TRAP: trap = 1'b1;
                default: state_d = S_TRAP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            // A FETCH stall also loops to FETCH but retires nothing.
            if (state_q != S_FETCH && state_d == S_FETCH) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: per-instruction phase-string model
// plus directed cycle-level literal checks.
module tb_multicycle_ctrl;

    localparam logic [5:0] T_R    = 6'd0;
    localparam logic [5:0] T_ADDI = 6'd1;
    localparam logic [5:0] T_BEQ  = 6'd5;
    localparam logic [5:0] T_BNE  = 6'd6;
    localparam logic [5:0] T_LW   = 6'd10;
    localparam logic [5:0] T_SW   = 6'd11;
    localparam logic [5:0] T_J    = 6'd12;
    localparam logic [5:0] T_JAL  = 6'd13;
    localparam logic [5:0] T_BAD  = 6'b111111;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic        zero_ext;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [1:0]  mem_to_reg;
    logic        trap;
    logic [31:0] retired;
    logic [20:0] dut_vec;

    int checks = 0;
    int errors = 0;
    int m_pos;
    logic [31:0] m_ret;

    multicycle_ctrl #(.RETIRE_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct      (funct),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .zero_ext   (zero_ext),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .trap       (trap),
        .retired    (retired)
    );

    assign dut_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                      alu_src_a, alu_src_b, alu_op, zero_ext, reg_write,
                      reg_dst, mem_to_reg, trap};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Phase letters each instruction walks through: F D E M W, T = trapped.
    function automatic string seq_of(input logic [5:0] op, input logic [5:0] fn);
        if (op == T_R) return (fn == 6'd8) ? "FD" : "FDEW";
        if (op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd7, 6'd8, 6'd9}) return "FDEW";
        if (op == T_BEQ || op == T_BNE) return "FDE";
        if (op == T_LW) return "FDEMW";
        if (op == T_SW) return "FDEM";
        if (op == T_J || op == T_JAL) return "FD";
        return "FDT";
    endfunction

    function automatic logic [20:0] expect_out(input byte ph,
        input logic [5:0] op, input logic [5:0] fn, input logic rdy,
        input logic z);
        logic       mreq = 1'b0, mwe = 1'b0, io = 1'b0, irw = 1'b0;
        logic       pcw = 1'b0, srca = 1'b0, zx = 1'b0, rw = 1'b0, tr = 1'b0;
        logic [1:0] pcs = 2'd0, srcb = 2'd0, rd = 2'd0, m2r = 2'd0;
        logic [3:0] aop = 4'd0;
        logic       rtype = (op == T_R);
        logic       jr = rtype && (fn == 6'd8);
        logic       ialu = op inside {6'd1, 6'd2, 6'd3, 6'd4, 6'd7, 6'd8, 6'd9};
        if (ph == "F") begin
            mreq = 1'b1;
            srcb = 2'd1;
            if (rdy) begin
                irw = 1'b1;
                pcw = 1'b1;
            end
        end else if (ph == "D") begin
            srcb = 2'd3;
            if (op == T_J || op == T_JAL) begin
                pcw = 1'b1;
                pcs = 2'd2;
            end
            if (op == T_JAL) begin
                rw  = 1'b1;
                rd  = 2'd2;
                m2r = 2'd2;
            end
            if (jr) begin
                pcw = 1'b1;
                pcs = 2'd3;
            end
        end else if (ph == "E") begin
            srca = 1'b1;
            if (rtype) begin
                aop = 4'd2;
            end else if (ialu) begin
                srcb = 2'd2;
                zx   = op inside {6'd2, 6'd3, 6'd4};
                case (op)
                    6'd2: aop = 4'd3;
                    6'd3: aop = 4'd4;
                    6'd4: aop = 4'd5;
                    6'd7: aop = 4'd7;
                    6'd8: aop = 4'd8;
                    6'd9: aop = 4'd6;
                    default: aop = 4'd0;
                endcase
            end else if (op == T_BEQ || op == T_BNE) begin
                aop = 4'd1;
                pcs = 2'd1;
                pcw = (op == T_BEQ) ? z : !z;
            end else begin
                srcb = 2'd2;
            end
        end else if (ph == "M") begin
            mreq = 1'b1;
            io   = 1'b1;
            mwe  = (op == T_SW);
        end else if (ph == "W") begin
            rw  = 1'b1;
            rd  = rtype ? 2'd1 : 2'd0;
            m2r = (op == T_LW) ? 2'd1 : 2'd0;
        end else if (ph == "T") begin
            tr = 1'b1;
        end
        return {mreq, mwe, io, irw, pcw, pcs, srca, srcb, aop, zx, rw, rd, m2r, tr};
    endfunction

    // Compare process: checks every cycle, then advances the model.
    initial begin : compare
        string s;
        byte   ph;
        m_pos = 0;
        m_ret = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                m_pos = 0;
                m_ret = '0;
                chk("ctrl_in_reset", 32'(dut_vec), 32'd0);
                chk("retired_in_reset", retired, 32'd0);
            end else begin
                s = seq_of(opcode, funct);
                chk("ctrl", 32'(dut_vec),
                    32'(expect_out(s[m_pos], opcode, funct, mem_ready, alu_zero)));
                chk("retired", retired, m_ret);
            end
            @(posedge clk);
            if (!rst_n) begin
                m_pos = 0;
                m_ret = '0;
            end else begin
                s  = seq_of(opcode, funct);
                ph = s[m_pos];
                if (ph == "T") begin
                end else if ((ph == "F" || ph == "M") && !mem_ready) begin
                end else begin
                    m_pos++;
                    if (m_pos == s.len()) begin
                        m_pos = 0;
                        m_ret++;
                    end
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] op,
                       input logic [5:0] fn, input logic rdy, input logic z);
        @(negedge clk);
        rst_n     = r;
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        alu_zero  = z;
        #2;
    endtask

    initial begin : stim
        string s;
        int    trap_cnt;
        rst_n     = 1'b0;
        opcode    = '0;
        funct     = '0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        trap_cnt  = 0;

        cyc(0, T_ADDI, 0, 1, 0);
        cyc(0, T_ADDI, 0, 1, 0);
        chk("reset_mem_req", mem_req, 0);
        chk("reset_trap", trap, 0);
        chk("reset_retired", retired, 0);

        // ADDI, zero-wait: 4 cycles
        cyc(1, T_ADDI, 0, 1, 0);
        chk("addi_fetch_req", mem_req, 1);
        chk("addi_fetch_irw", ir_write, 1);
        cyc(1, T_ADDI, 0, 1, 0);
        cyc(1, T_ADDI, 0, 1, 0);
        chk("addi_exec_aluop", alu_op, 0);
        chk("addi_exec_srcb", alu_src_b, 2);
        cyc(1, T_ADDI, 0, 1, 0);
        chk("addi_wb_rw", reg_write, 1);
        chk("addi_wb_dst", reg_dst, 0);
        chk("addi_wb_ret", retired, 0);

        // JAL: 2 cycles
        cyc(1, T_JAL, 0, 1, 0);
        chk("addi_retired", retired, 1);
        cyc(1, T_JAL, 0, 1, 0);
        chk("jal_pcw", pc_write, 1);
        chk("jal_pcsrc", pc_src, 2);
        chk("jal_rw", reg_write, 1);
        chk("jal_dst", reg_dst, 2);
        chk("jal_m2r", mem_to_reg, 2);

        // LW: 2 fetch waits, 3 mem waits -> 10 cycles
        for (int i = 0; i < 2; i++) begin
            cyc(1, T_LW, 0, 0, 0);
            chk("lw_fwait_req", mem_req, 1);
            chk("lw_fwait_iord", iord, 0);
            chk("lw_fwait_irw", ir_write, 0);
        end
        chk("jal_retired", retired, 2);
        cyc(1, T_LW, 0, 1, 0);
        cyc(1, T_LW, 0, 1, 0);
        cyc(1, T_LW, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, T_LW, 0, 0, 0);
            chk("lw_mwait_req", mem_req, 1);
            chk("lw_mwait_iord", iord, 1);
            chk("lw_mwait_we", mem_we, 0);
        end
        cyc(1, T_LW, 0, 1, 0);
        cyc(1, T_LW, 0, 1, 0);
        chk("lw_wb_m2r", mem_to_reg, 1);
        chk("lw_wb_ret", retired, 2);

        // BEQ then BNE with alu_zero=1: 3 cycles each
        cyc(1, T_BEQ, 0, 1, 1);
        chk("lw_retired", retired, 3);
        cyc(1, T_BEQ, 0, 1, 1);
        cyc(1, T_BEQ, 0, 1, 1);
        chk("beq_pcw", pc_write, 1);
        chk("beq_pcsrc", pc_src, 1);
        cyc(1, T_BNE, 0, 1, 1);
        chk("beq_retired", retired, 4);
        cyc(1, T_BNE, 0, 1, 1);
        cyc(1, T_BNE, 0, 1, 1);
        chk("bne_pcw", pc_write, 0);

        // Illegal opcode traps until reset
        cyc(1, T_BAD, 0, 1, 0);
        chk("bne_retired", retired, 5);
        cyc(1, T_BAD, 0, 1, 0);
        chk("bad_decode_trap", trap, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, T_BAD, 0, 1'($urandom), 0);
            chk("trap_flag", trap, 1);
            chk("trap_req", mem_req, 0);
            chk("trap_pcw", pc_write, 0);
            chk("trap_rw", reg_write, 0);
        end
        cyc(0, T_SW, 0, 1, 0);
        chk("trap_cleared", trap, 0);

        // SW aborted by reset during a MEM wait
        cyc(1, T_SW, 0, 1, 0);
        chk("post_trap_req", mem_req, 1);
        chk("post_trap_ret", retired, 0);
        cyc(1, T_SW, 0, 1, 0);
        cyc(1, T_SW, 0, 1, 0);
        cyc(1, T_SW, 0, 0, 0);
        chk("sw_mem_we", mem_we, 1);
        chk("sw_mem_iord", iord, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_req", mem_req, 0);
        chk("abort_we", mem_we, 0);
        chk("abort_iord", iord, 0);
        cyc(0, T_SW, 0, 0, 0);
        cyc(1, T_SW, 0, 0, 0);
        chk("abort_fetch_req", mem_req, 1);
        chk("abort_retired", retired, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0 || trap_cnt > 22) begin
                rst_n    = 1'b0;
                trap_cnt = 0;
            end
            if (m_pos == 0) begin
                if ($urandom_range(0, 39) == 0)
                    opcode = 6'($urandom_range(14, 63));
                else
                    opcode = 6'($urandom_range(0, 13));
                if ($urandom_range(0, 3) == 0)
                    funct = 6'd8;
                else
                    funct = 6'($urandom_range(0, 63));
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            alu_zero  = 1'($urandom);
            s = seq_of(opcode, funct);
            if (s[m_pos] == "T") trap_cnt++;
            else trap_cnt = 0;
        end

        @(negedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
